// File: rtl/cgra_input_streamer_if.sv
// cgra_input_streamer_if: in-order read request/response port between the streamer (master) and the bus adapter (slave)
interface cgra_input_streamer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] rsp_data;
  modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_err);
  modport slave  (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/cgra_input_streamer.sv
// cgra_input_streamer: strided multi-channel memory fetch into per-channel FIFOs feeding CGRA input nodes.
// Define STREAMER_PERF_COUNTERS_EN to build the saturating request-stall counter on stall_cycles_o.
module cgra_input_streamer #(
  parameter int NUM_CHANNELS    = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SIZE_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] base_addr_i,
  input  logic [NUM_CHANNELS*SIZE_WIDTH-1:0] size_i,
  input  logic [NUM_CHANNELS*SIZE_WIDTH-1:0] stride_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               error_o,
  cgra_input_streamer_if.master              rd,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_o,
  output logic [NUM_CHANNELS-1:0]            data_valid_o,
  input  logic [NUM_CHANNELS-1:0]            data_ready_i,
  output logic [31:0]                        stall_cycles_o
);
  localparam int CW  = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int FW  = $clog2(FIFO_DEPTH);
  localparam int FCW = FW + 1;
  localparam int TW  = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TCW = TW + 1;
  localparam logic [FCW:0]   DEPTH_C = (FCW+1)'(FIFO_DEPTH);
  localparam logic [TCW-1:0] MAXO_C  = TCW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [SIZE_WIDTH-1:0] size_q [NUM_CHANNELS], size_d [NUM_CHANNELS];
  logic [SIZE_WIDTH-1:0] stride_q [NUM_CHANNELS], stride_d [NUM_CHANNELS];
  logic [SIZE_WIDTH-1:0] issued_q [NUM_CHANNELS], issued_d [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0] addr_q [NUM_CHANNELS], addr_d [NUM_CHANNELS];
  logic [FCW-1:0]        infl_q [NUM_CHANNELS], infl_d [NUM_CHANNELS];
  logic [FCW-1:0]        fcnt_q [NUM_CHANNELS], fcnt_d [NUM_CHANNELS];
  logic [FW-1:0]         frp_q [NUM_CHANNELS], frp_d [NUM_CHANNELS];
  logic [FW-1:0]         fwp_q [NUM_CHANNELS], fwp_d [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] mem_q [NUM_CHANNELS][FIFO_DEPTH];
  logic [CW-1:0]         tag_q [2**TW];
  logic [TW-1:0]         trp_q, trp_d, twp_q, twp_d;
  logic [TCW-1:0]        tcnt_q, tcnt_d;
  logic [CW-1:0]         rr_q, rr_d, hold_ch_q, hold_ch_d, grant, rsp_ch;
  logic                  hold_q, hold_d, error_q, error_d;
  logic                  req_valid, fire, rsp_fire, all_done;
  logic [NUM_CHANNELS-1:0] elig, iss, push, pop;

  function automatic logic [CW-1:0] wrap(input int v);
    return CW'(v >= NUM_CHANNELS ? v - NUM_CHANNELS : v);
  endfunction

  // Credit rule: a channel only asks for words its FIFO is guaranteed to hold.
  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      elig[c] = state_q == RUN && issued_q[c] < size_q[c] && tcnt_q < MAXO_C &&
                ({1'b0, fcnt_q[c]} + {1'b0, infl_q[c]}) < DEPTH_C;
  end

  // A stalled request keeps its channel; otherwise search starts after the last grant.
  always_comb begin
    grant = hold_ch_q;
    req_valid = hold_q;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (!req_valid && elig[wrap(int'(rr_q) + i)]) begin
        grant = wrap(int'(rr_q) + i);
        req_valid = 1'b1;
      end
  end

  assign fire     = req_valid && rd.req_ready;
  assign rsp_fire = rd.rsp_valid && rd.rsp_ready;
  assign rsp_ch   = tag_q[trp_q];

  always_comb begin
    size_d = size_q;
    stride_d = stride_q;
    issued_d = issued_q;
    addr_d = addr_q;
    infl_d = infl_q;
    fcnt_d = fcnt_q;
    frp_d = frp_q;
    fwp_d = fwp_q;
    iss = '0;
    push = '0;
    pop = '0;
    twp_d = twp_q + TW'(fire);
    trp_d = trp_q + TW'(rsp_fire);
    tcnt_d = tcnt_q + TCW'(fire) - TCW'(rsp_fire);
    rr_d = fire ? wrap(int'(grant) + 1) : rr_q;
    hold_d = req_valid && !rd.req_ready;
    hold_ch_d = grant;
    error_d = (state_q == IDLE && start_i) ? 1'b0 : error_q | (rsp_fire && rd.rsp_err);
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      iss[c] = fire && grant == CW'(c);
      push[c] = rsp_fire && rsp_ch == CW'(c);
      pop[c] = data_valid_o[c] && data_ready_i[c];
      fcnt_d[c] = fcnt_q[c] + FCW'(push[c]) - FCW'(pop[c]);
      frp_d[c] = frp_q[c] + FW'(pop[c]);
      fwp_d[c] = fwp_q[c] + FW'(push[c]);
      infl_d[c] = infl_q[c] + FCW'(iss[c]) - FCW'(push[c]);
      issued_d[c] = issued_q[c] + SIZE_WIDTH'(iss[c]);
      addr_d[c] = iss[c] ? addr_q[c] + ADDR_WIDTH'(stride_q[c]) : addr_q[c];
      if (state_q == IDLE && start_i) begin
        size_d[c] = size_i[c*SIZE_WIDTH +: SIZE_WIDTH];
        stride_d[c] = stride_i[c*SIZE_WIDTH +: SIZE_WIDTH];
        addr_d[c] = base_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
        issued_d[c] = '0;
      end
    end
    // Completion looks at next-cycle counts so done_o follows the last pop by one cycle.
    all_done = tcnt_d == '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      all_done = all_done && issued_d[c] == size_q[c] && fcnt_d[c] == '0;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = state_q == IDLE ? (start_i ? RUN : IDLE) :
              state_q == RUN  ? (all_done ? DONE : RUN) : IDLE;

  always_comb begin
    busy_o = state_q != IDLE;
    done_o = state_q == DONE;
    error_o = error_q;
    rd.req_valid = req_valid;
    rd.req_addr = req_valid ? addr_q[grant] : '0;
    rd.rsp_ready = tcnt_q != '0;
    data_valid_o = '0;
    data_o = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      data_valid_o[c] = fcnt_q[c] != '0;
      data_o[c*DATA_WIDTH +: DATA_WIDTH] = data_valid_o[c] ? mem_q[c][frp_q[c]] : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      size_q <= '{default: '0};
      stride_q <= '{default: '0};
      issued_q <= '{default: '0};
      addr_q <= '{default: '0};
      infl_q <= '{default: '0};
      fcnt_q <= '{default: '0};
      frp_q <= '{default: '0};
      fwp_q <= '{default: '0};
      trp_q <= '0;
      twp_q <= '0;
      tcnt_q <= '0;
      rr_q <= '0;
      hold_q <= 1'b0;
      hold_ch_q <= '0;
      error_q <= 1'b0;
    end else begin
      size_q <= size_d;
      stride_q <= stride_d;
      issued_q <= issued_d;
      addr_q <= addr_d;
      infl_q <= infl_d;
      fcnt_q <= fcnt_d;
      frp_q <= frp_d;
      fwp_q <= fwp_d;
      trp_q <= trp_d;
      twp_q <= twp_d;
      tcnt_q <= tcnt_d;
      rr_q <= rr_d;
      hold_q <= hold_d;
      hold_ch_q <= hold_ch_d;
      error_q <= error_d;
    end

  always_ff @(posedge clk_i) begin
    if (fire) tag_q[twp_q] <= grant;
    if (rsp_fire) mem_q[rsp_ch][fwp_q[rsp_ch]] <= rd.rsp_data;
  end

`ifdef STREAMER_PERF_COUNTERS_EN
  logic [31:0] stall_q, stall_d;
  always_comb
    stall_d = (state_q == IDLE && start_i) ? '0 :
              (state_q == RUN && req_valid && !rd.req_ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) stall_q <= '0;
    else stall_q <= stall_d;
  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_cgra_input_streamer.sv
// tb_cgra_input_streamer: directed checks of the input streamer against a one-cycle-latency memory that returns the address as data
module tb_cgra_input_streamer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [127:0] base, data;
  logic [63:0] size, stride;
  logic busy, done, error;
  logic [3:0] dvalid, dready;
  logic [31:0] stall;
  logic [31:0] pend [$];
  logic [31:0] req_log [$];
  logic [31:0] last_word [4];
  logic [31:0] mb [4] = '{32'h8000_0000, 32'h8100_0004, 32'h8200_0008, 32'h8300_000C};
  logic [31:0] a0;
  int passed = 0, fails = 0, total = 0;
  int cyc = 0, rsp_idx = 0, err_at = -1, done_cnt = 0, done_cyc = 0, last_pop = 0, words = 0, w0;
`ifdef STREAMER_PERF_COUNTERS_EN
  localparam logic [31:0] STALL_EXP = 32'd10;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  cgra_input_streamer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rd ();
  cgra_input_streamer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .size_i(size), .stride_i(stride),
    .busy_o(busy), .done_o(done), .error_o(error), .rd(rd), .data_o(data), .data_valid_o(dvalid),
    .data_ready_i(dready), .stall_cycles_o(stall));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst) pend.delete();
    else begin
      cyc++;
      if (rd.rsp_valid && rd.rsp_ready) begin
        void'(pend.pop_front());
        rsp_idx++;
      end
      if (rd.req_valid && rd.req_ready) begin
        pend.push_back(rd.req_addr);
        req_log.push_back(rd.req_addr);
      end
      for (int c = 0; c < 4; c++)
        if (dvalid[c] && dready[c]) begin
          words++;
          last_pop = cyc;
          last_word[c] = data[c*32 +: 32];
        end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end

  always @(negedge clk) begin
    rd.rsp_valid = pend.size() != 0;
    rd.rsp_data = pend.size() != 0 ? pend[0] : '0;
    rd.rsp_err = pend.size() != 0 && rsp_idx == err_at;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic go;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic main_cfg;
    base = {mb[3], mb[2], mb[1], mb[0]};
    size = {4{16'd8}};
    stride = {4{16'd8}};
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) step;
    chk({tag, "_busy_after_done"}, busy, 1'b0);
    repeat (3) step;
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  function automatic int cnt_ch(input int c);
    int n = 0;
    foreach (req_log[k]) if (req_log[k][25:24] == 2'(c)) n++;
    return n;
  endfunction

  initial begin
    base = '0; size = '0; stride = '0; dready = '1; rd.req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {busy, done, error, rd.req_valid, rd.rsp_ready, dvalid}, 0);
    chk("rst_addr", rd.req_addr, 0);
    chk("rst_data", data[63:0] | data[127:64], 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    step;
    // main streaming run
    main_cfg;
    req_log.delete();
    w0 = words;
    go;
    chk("a_busy_t1", busy, 1'b1);
    chk("a_valid_t1", rd.req_valid, 1'b1);
    chk("a_first_addr", rd.req_addr, 32'h8000_0000);
    wait_done("a");
    chk("a_req_count", req_log.size(), 32);
    for (int k = 0; k < 32; k++) chk("a_addr_seq", req_log[k], mb[k%4] + 32'(8*(k/4)));
    chk("a_words", words - w0, 32);
    chk("a_done_after_last_pop", done_cyc - last_pop, 1);
    chk("a_ch0_last", last_word[0], 32'h8000_0038);
    chk("a_ch3_last", last_word[3], 32'h8300_0044);
    chk("a_error", error, 1'b0);
    // channel 2 back-pressured by the CGRA
    req_log.delete();
    dready = 4'b1011;
    go;
    repeat (100) step;
    chk("b_ch2_reqs", cnt_ch(2), 4);
    chk("b_ch0_reqs", cnt_ch(0), 8);
    chk("b_ch3_reqs", cnt_ch(3), 8);
    chk("b_still_busy", busy, 1'b1);
    chk("b_ch2_valid", dvalid[2], 1'b1);
    chk("b_ch2_head", data[64 +: 32], 32'h8200_0008);
    dready = 4'b1111;
    wait_done("b");
    chk("b_ch2_reqs_final", cnt_ch(2), 8);
    // request port stalled for ten cycles
    go;
    repeat (3) step;
    rd.req_ready = 1'b0;
    a0 = rd.req_addr;
    repeat (10) step;
    chk("c_addr_stable", rd.req_addr, a0);
    chk("c_valid_held", rd.req_valid, 1'b1);
    chk("c_stall", stall, STALL_EXP);
    rd.req_ready = 1'b1;
    wait_done("c");
    // error on the fourth response of the run
    err_at = rsp_idx + 3;
    w0 = words;
    go;
    wait_done("d");
    chk("d_error", error, 1'b1);
    chk("d_words", words - w0, 32);
    err_at = -1;
    repeat (5) step;
    chk("d_error_sticky", error, 1'b1);
    // all sizes zero: immediate completion, error cleared by start
    size = '0;
    go;
    chk("e_busy", busy, 1'b1);
    chk("e_error_cleared", error, 1'b0);
    chk("e_no_req", rd.req_valid, 1'b0);
    chk("e_done_early", done, 1'b0);
    step;
    chk("e_done", done, 1'b1);
    step;
    chk("e_idle", {busy, done}, 2'b00);
    // second start during RUN is ignored
    main_cfg;
    req_log.delete();
    go;
    repeat (5) step;
    size = {4{16'd1}};
    go;
    main_cfg;
    chk("f_busy", busy, 1'b1);
    wait_done("f");
    chk("f_req_count", req_log.size(), 32);
    // asynchronous reset in the middle of a run
    go;
    repeat (6) step;
    rst = 1'b1;
    #1;
    chk("g_ctrl", {busy, done, error, rd.req_valid, rd.rsp_ready, dvalid}, 0);
    chk("g_addr", rd.req_addr, 0);
    chk("g_data", data[63:0] | data[127:64], 0);
    chk("g_stall", stall, 0);
    step;
    rst = 1'b0;
    step;
    // address wraps at the top of the address space
    req_log.delete();
    base = {96'd0, 32'hFFFF_FFF8};
    size = {48'd0, 16'd3};
    stride = {4{16'd8}};
    go;
    wait_done("h");
    chk("h_req_count", req_log.size(), 3);
    chk("h_addr0", req_log.size() > 0 ? req_log[0] : 32'hDEAD, 32'hFFFF_FFF8);
    chk("h_addr1", req_log.size() > 1 ? req_log[1] : 32'hDEAD, 32'h0000_0000);
    chk("h_addr2", req_log.size() > 2 ? req_log[2] : 32'hDEAD, 32'h0000_0008);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cgra_input_streamer.md
# cgra_input_streamer

Parametrised multi-channel input streamer that fetches strided word sequences from memory over a simple in-order read port and delivers them to the CGRA input nodes through per-channel FIFOs. It is the generalised successor of the fixed 4-node input state machine. Channel count, data width, FIFO depth and outstanding-read limit are now parameters, and it adds round-robin request arbitration, credit-based flow control and error reporting. It sits between the control unit (start/done) and the AXI-Lite master adapter (read port).

## Interface
- NUM_CHANNELS, 4, number of CGRA input nodes (1..16)
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width per channel
- SIZE_WIDTH, 16, width of size and stride fields
- FIFO_DEPTH, 4, per-channel FIFO entries (power of 2, ≥2)
- MAX_OUTSTANDING, 8, read requests in flight (power of 2)
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  start pulse; config inputs sampled in the same cycle
- base_addr_i  in  NUM_CHANNELS*ADDR_WIDTH  per-channel start byte address
- size_i  in  NUM_CHANNELS*SIZE_WIDTH  per-channel word count
- stride_i  in  NUM_CHANNELS*SIZE_WIDTH  per-channel byte stride (unsigned)
- busy_o  out  1  high from the cycle after accepted start until done_o
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  sticky read-error flag, cleared on next accepted start
- rd_req_valid_o / rd_req_ready_i  out/in  1/1  read request handshake
- rd_req_addr_o  out  ADDR_WIDTH  request byte address
- rd_rsp_valid_i / rd_rsp_ready_o  in/out  1/1  read response handshake (in order)
- rd_rsp_data_i  in  DATA_WIDTH  response word
- rd_rsp_err_i  in  1  response error
- data_o  out  NUM_CHANNELS*DATA_WIDTH  FIFO head per channel
- data_valid_o / data_ready_i  out/in  NUM_CHANNELS each  per-channel CGRA handshake
- stall_cycles_o  out  32  performance counter (see Configuration)

## Operation
- States IDLE → RUN → DONE → IDLE. start_i in IDLE latches config, clears error_o, and resets per-channel issue counters to 0. It moves to RUN. start_i outside IDLE is ignored.
- Channel c is eligible when issued_c < size_c and fifo_count_c + inflight_c < FIFO_DEPTH (credit rule), and total in-flight < MAX_OUTSTANDING.
- Round-robin arbiter: search begins at the channel after the last granted one. After reset the pointer is 0, so channel 0 is checked first.
- Address of word k = base_c + k*stride_c, computed incrementally by adding stride, modulo 2^ADDR_WIDTH (wraps silently). stride 0 re-reads base.
- While rd_req_valid_o && !rd_req_ready_i, address and channel are held stable and no re-arbitration occurs.
- On request handshake, the channel id is pushed into a tag FIFO (depth MAX_OUTSTANDING). Each response pops the tag and writes the word to that channel's FIFO.
- rd_rsp_ready_o = 1 whenever the tag FIFO is non-empty. The credit rule guarantees FIFO space.
- rd_rsp_err_i=1 sets error_o. The word is still pushed so the channel counts stay consistent.
- size_c = 0: channel issues nothing and counts as complete.
- RUN → DONE when all channels are fully issued, the tag FIFO is empty, and all channel FIFOs are empty. DONE lasts 1 cycle with done_o=1.
- Simultaneous FIFO push and pop on a full FIFO is allowed. Count is unchanged.

## Timing
- Reset values: busy_o=0, done_o=0, error_o=0, rd_req_valid_o=0, rd_req_addr_o=0, rd_rsp_ready_o=0, data_valid_o=0, data_o=0, stall_cycles_o=0. Arbiter pointer=0, all FIFOs empty.
- start_i at cycle T: busy_o=1 and the earliest rd_req_valid_o both occur at T+1.
- Response accepted at cycle t: data_valid_o for that word at t+1 (registered FIFO).
- Last FIFO pop at cycle t: done_o=1 at t+1, busy_o=0 at t+2.
- rst_i asserted mid-RUN: all state clears immediately. Responses still in flight after reset are dropped; the read port must be reset with the streamer.

## Configuration
- STREAMER_PERF_COUNTERS_EN defined: stall_cycles_o counts RUN cycles with rd_req_valid_o=1 && rd_req_ready_i=0. It clears on accepted start and saturates at 2^32-1.
- Not defined: stall_cycles_o tied to 0 and no counter logic is instantiated.

## Test plan
- 4 channels, base 0x8000_0000/0x8100_0004/0x8200_0008/0x8300_000C, size 8, stride 8, rd_req_ready_i=1, data_ready_i=1 → 32 requests, grants rotate 0,1,2,3. Channel 0 addresses are 0x8000_0000, 0x8000_0008, …, 0x8000_0038. Exactly one done_o pulse.
- data_ready_i[2]=0 held, FIFO_DEPTH 4 → channel 2 issues exactly 4 requests then stops. Other channels complete. Releasing ready finishes channel 2 and produces done_o.
- rd_req_ready_i=0 for 10 cycles during RUN → rd_req_addr_o stable. With the macro, stall_cycles_o=10; without it, 0.
- Response 3 has rd_rsp_err_i=1 → error_o=1 until next start, all words delivered, done_o pulses.
- size {0,0,0,0} → no requests, done_o at T+2. Second start_i during RUN ignored. rst_i mid-RUN returns all outputs to reset values.
- base 0xFFFF_FFF8, stride 8, size 3 → addresses 0xFFFF_FFF8, 0x0000_0000, 0x0000_0008.
